// File: rtl/rst_sequencer.sv
// Staged reset-release sequencer: holds all channels, releases them one by one, then counts RUN cycles.
// Optional watchdog compiled in with `define RST_SEQ_WATCHDOG_EN.
module rst_sequencer #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGGER     = 4,
    parameter int unsigned WDT_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_rst_req,
    input  logic              wdt_kick,
    output logic [NUM_CH-1:0] ch_rst,
    output logic              all_released,
    output logic              seq_busy,
    output logic [31:0]       run_cycles,
    output logic              wdt_fired
);

    localparam int unsigned CntMax  = HOLD_CYCLES + NUM_CH * STAGGER;
    localparam int unsigned CntW    = $clog2(CntMax + 1);
    localparam int unsigned LastRel = HOLD_CYCLES + (NUM_CH - 1) * STAGGER;

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StRelease = 2'd1,
        StRun     = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NUM_CH-1:0]   ch_rst_q, ch_rst_d;
    logic                all_rel_q, all_rel_d;
    logic                seq_busy_q;
    logic [31:0]         run_q, run_d;
    logic                wdt_expire;

    // cnt_q holds the edge number within the current sequence; a restart edge counts as edge 1.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_rst_d  = ch_rst_q;
        all_rel_d = all_rel_q;
        run_d     = run_q;
        if (soft_rst_req || wdt_expire) begin
            state_d   = StHold;
            cnt_d     = CntW'(1);
            ch_rst_d  = '1;
            all_rel_d = 1'b0;
            run_d     = '0;
        end else begin
            unique case (state_q)
                StHold, StRelease: begin
                    cnt_d = cnt_q + CntW'(1);
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        if (cnt_d >= CntW'(HOLD_CYCLES + k * STAGGER)) begin
                            ch_rst_d[k] = 1'b0;
                        end
                    end
                    if (cnt_d == CntW'(LastRel)) begin
                        state_d   = StRun;
                        all_rel_d = 1'b1;
                    end else if (cnt_d >= CntW'(HOLD_CYCLES)) begin
                        state_d = StRelease;
                    end
                end
                StRun: begin
                    if (run_q != 32'hFFFF_FFFF) begin
                        run_d = run_q + 32'd1;
                    end
                end
                default: state_d = StHold;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StHold;
            cnt_q      <= '0;
            ch_rst_q   <= '1;
            all_rel_q  <= 1'b0;
            seq_busy_q <= 1'b1;
            run_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_rst_q   <= ch_rst_d;
            all_rel_q  <= all_rel_d;
            seq_busy_q <= ~all_rel_d;
            run_q      <= run_d;
        end
    end

`ifdef RST_SEQ_WATCHDOG_EN
    localparam int unsigned WdtW = $clog2(WDT_CYCLES + 1);

    logic [WdtW-1:0] wdt_cnt_q, wdt_cnt_d;
    logic            wdt_fired_q, wdt_fired_d;

    // A kick in the expiry cycle suppresses the expiry.
    assign wdt_expire = (state_q == StRun) && (wdt_cnt_q == WdtW'(WDT_CYCLES)) && !wdt_kick;

    always_comb begin
        wdt_cnt_d   = '0;
        wdt_fired_d = wdt_fired_q | wdt_expire;
        if ((state_q == StRun) && !wdt_kick && !soft_rst_req &&
            (wdt_cnt_q != WdtW'(WDT_CYCLES))) begin
            wdt_cnt_d = wdt_cnt_q + WdtW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt_q   <= '0;
            wdt_fired_q <= 1'b0;
        end else begin
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_fired_q <= wdt_fired_d;
        end
    end

    assign wdt_fired = wdt_fired_q;
`else
    logic unused_wdt_kick;
    assign unused_wdt_kick = wdt_kick;
    assign wdt_expire      = 1'b0;
    assign wdt_fired       = 1'b0;
`endif

    assign ch_rst       = ch_rst_q;
    assign all_released = all_rel_q;
    assign seq_busy     = seq_busy_q;
    assign run_cycles   = run_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: cycle-by-cycle model comparison plus directed literal checks.
// Build with RST_SEQ_WATCHDOG_EN defined to also exercise the watchdog scenarios.
module tb_rst_sequencer;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned HOLD   = 4;
    localparam int unsigned STAG   = 2;
    localparam int unsigned WDT    = 8;
    localparam int          LAST   = HOLD + (NUM_CH - 1) * STAG;
    localparam longint      RUNMAX = 64'h0000_0000_FFFF_FFFF;
`ifdef RST_SEQ_WATCHDOG_EN
    localparam bit WdtEn = 1'b1;
`else
    localparam bit WdtEn = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              soft_rst_req;
    logic              wdt_kick;
    logic [NUM_CH-1:0] ch_rst;
    logic              all_released;
    logic              seq_busy;
    logic [31:0]       run_cycles;
    logic              wdt_fired;

    int     checks = 0;
    int     errors = 0;
    longint m_run  = 0;

    rst_sequencer #(
        .NUM_CH      (NUM_CH),
        .HOLD_CYCLES (HOLD),
        .STAGGER     (STAG),
        .WDT_CYCLES  (WDT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .soft_rst_req (soft_rst_req),
        .wdt_kick     (wdt_kick),
        .ch_rst       (ch_rst),
        .all_released (all_released),
        .seq_busy     (seq_busy),
        .run_cycles   (run_cycles),
        .wdt_fired    (wdt_fired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: e = edge number within the current sequence, run state = every channel past its slot.
    initial begin : model_cmp
        int                e;
        int                wdt;
        bit                fired;
        bit                forced;
        bit                prev_run;
        bit                expire;
        bit                exp_all;
        logic [NUM_CH-1:0] exp_ch;
        e = 0; wdt = 0; fired = 1'b0; forced = 1'b1;
        forever begin
            @(posedge clk);
            prev_run = !forced && (e >= LAST);
            expire   = WdtEn && prev_run && (wdt == WDT) && !wdt_kick;
            if (rst) begin
                e = 0; wdt = 0; fired = 1'b0; forced = 1'b1; m_run = 0;
            end else if (soft_rst_req || expire) begin
                e = 1; wdt = 0; forced = 1'b1; m_run = 0;
                if (expire) fired = 1'b1;
            end else begin
                forced = 1'b0;
                if (prev_run) begin
                    m_run = (m_run >= RUNMAX) ? RUNMAX : m_run + 1;
                    if (wdt_kick) wdt = 0;
                    else if (wdt < WDT) wdt++;
                end else begin
                    if (e < LAST) e++;
                    wdt = 0;
                end
            end
            for (int k = 0; k < NUM_CH; k++) exp_ch[k] = forced || (e < HOLD + k * STAG);
            exp_all = !forced && (e >= LAST);
            @(negedge clk);
            check("model_ch_rst", 64'(ch_rst), 64'(exp_ch));
            check("model_all_released", 64'(all_released), 64'(exp_all));
            check("model_seq_busy", 64'(seq_busy), 64'(!exp_all));
            check("model_run_cycles", 64'(run_cycles), 64'(m_run));
            check("model_wdt_fired", 64'(wdt_fired), 64'(fired));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin : stim
        rst = 1'b1; soft_rst_req = 1'b0; wdt_kick = 1'b0;
        step(3);
        check("reset_ch_rst", 64'(ch_rst), 64'h7);
        check("reset_all_released", 64'(all_released), 64'h0);
        check("reset_seq_busy", 64'(seq_busy), 64'h1);
        check("reset_run_cycles", 64'(run_cycles), 64'h0);
        check("reset_wdt_fired", 64'(wdt_fired), 64'h0);

        // Basic release timing: edges 4, 6, 8
        rst = 1'b0;
        step(3); check("e3_ch", 64'(ch_rst), 64'h7);
        step(1); check("e4_ch", 64'(ch_rst), 64'h6);
        step(2); check("e6_ch", 64'(ch_rst), 64'h4);
        step(1); check("e7_all", 64'(all_released), 64'h0);
        step(1); check("e8_ch", 64'(ch_rst), 64'h0);
                 check("e8_all", 64'(all_released), 64'h1);
                 check("e8_run", 64'(run_cycles), 64'h0);
        step(1); check("e9_run", 64'(run_cycles), 64'h1);

        // Soft request sampled at edge 8 (during RELEASE)
        pulse_rst();
        step(7); soft_rst_req = 1'b1;
        step(1); soft_rst_req = 1'b0;
        check("soft_e8_ch", 64'(ch_rst), 64'h7);
        check("soft_e8_run", 64'(run_cycles), 64'h0);
        step(2); check("soft_e10_ch", 64'(ch_rst), 64'h7);
        step(1); check("soft_e11_ch", 64'(ch_rst), 64'h6);
        step(2); check("soft_e13_ch", 64'(ch_rst), 64'h4);
        step(2); check("soft_e15_ch", 64'(ch_rst), 64'h0);
                 check("soft_e15_all", 64'(all_released), 64'h1);

        // rst pulse mid-sequence at edge 6
        pulse_rst();
        step(5); rst = 1'b1;
        step(1); check("rst_mid_ch", 64'(ch_rst), 64'h7);
                 check("rst_mid_busy", 64'(seq_busy), 64'h1);
        rst = 1'b0;
        step(3); check("rst_mid_new_e3", 64'(ch_rst), 64'h7);
        step(1); check("rst_mid_new_e4", 64'(ch_rst), 64'h6);

        // Soft request in HOLD restarts the hold count
        pulse_rst();
        step(2); soft_rst_req = 1'b1;
        step(1); soft_rst_req = 1'b0;
        step(2); check("hold_soft_e3", 64'(ch_rst), 64'h7);
        step(1); check("hold_soft_e4", 64'(ch_rst), 64'h6);

        // Saturation of run_cycles (kicks keep a compiled-in watchdog quiet)
        wdt_kick = 1'b1;
        step(10);
        #2;
        force dut.run_q = 32'hFFFF_FFFE;
        m_run = 64'hFFFF_FFFE;
        #1;
        release dut.run_q;
        step(1); check("sat_first", 64'(run_cycles), 64'hFFFF_FFFF);
        for (int i = 0; i < 10; i++) begin
            step(1); check("sat_hold", 64'(run_cycles), 64'hFFFF_FFFF);
        end

        // Soft request in RUN
        wdt_kick = 1'b0; soft_rst_req = 1'b1;
        step(1); soft_rst_req = 1'b0;
        check("run_soft_ch", 64'(ch_rst), 64'h7);
        check("run_soft_run", 64'(run_cycles), 64'h0);

`ifdef RST_SEQ_WATCHDOG_EN
        // No kicks: expiry on the 9th RUN edge (RUN entered at edge 8)
        pulse_rst();
        step(16); check("wdt_e16_ch", 64'(ch_rst), 64'h0);
                  check("wdt_e16_fired", 64'(wdt_fired), 64'h0);
        step(1);  check("wdt_e17_ch", 64'(ch_rst), 64'h7);
                  check("wdt_e17_fired", 64'(wdt_fired), 64'h1);
        step(10); check("wdt_sticky", 64'(wdt_fired), 64'h1);

        // Kick in the expiry cycle wins
        pulse_rst();
        step(16); wdt_kick = 1'b1;
        step(1);  wdt_kick = 1'b0;
        check("kick_wins_ch", 64'(ch_rst), 64'h0);
        check("kick_wins_fired", 64'(wdt_fired), 64'h0);

        // Kick every 7 cycles: never expires
        pulse_rst();
        for (int i = 0; i < 100; i++) begin
            wdt_kick = (i % 7 == 0);
            step(1);
            check("kick7_fired", 64'(wdt_fired), 64'h0);
        end
        wdt_kick = 1'b0;
`endif

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
